i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 213 +++++++++++++++++++++
 tb/tb_i2s_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter slaved to codec-supplied SCLK/LRCLK. It double-buffers one
// stereo pair and shifts it out MSB first with the standard one-bit delay.
module i2s_tx #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                Reset_h,
    input  logic                sclk_in,
    input  logic                lrclk_in,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                dout,
    output logic                frame_strobe,
    output logic [15:0]         underrun_cnt
);

    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] SAMPLE_LIM = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] SLOT_LIM   = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [2:0]          sclk_sync_r;
    logic [1:0]          lrclk_sync_r;
    logic                lr_s_r;
    logic                lr_p_r;
    logic                lr_upd_r;
    logic                sclk_rise_s;
    logic                sclk_fall_s;
    logic                lr_fall_s;
    logic                lr_rise_s;
    logic                load_left_s;
    logic                load_right_s;
    logic                accept_s;
    logic                hold_full_r;
    logic [SAMPLE_W-1:0] hold_l_r;
    logic [SAMPLE_W-1:0] hold_r_r;
    logic [SAMPLE_W-1:0] frame_r_r;
    logic [SAMPLE_W-1:0] shift_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic                dout_r;
    logic                frame_strobe_r;
    logic [15:0]         underrun_cnt_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Edges come from stages 2 and 3, so each one is seen for exactly one clk.
    assign sclk_rise_s  = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s  = ~sclk_sync_r[1] & sclk_sync_r[2];
    // LRCLK changes are judged one clk after the SCLK-rise sample lands in lr_s/lr_p.
    assign lr_fall_s    = lr_upd_r & lr_p_r & ~lr_s_r;
    assign lr_rise_s    = lr_upd_r & ~lr_p_r & lr_s_r;
    assign sample_ready = ~hold_full_r & ~Reset_h;
    assign accept_s     = sample_valid & sample_ready;
    assign dout         = dout_r;
    assign frame_strobe = frame_strobe_r;
    assign underrun_cnt = underrun_cnt_r;

    // Synchronizers for the codec clocks.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            sclk_sync_r  <= 3'b000;
            lrclk_sync_r <= 2'b00;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[1:0], sclk_in};
            lrclk_sync_r <= {lrclk_sync_r[0], lrclk_in};
        end
    end

    // LRCLK sampled on SCLK rising edges, keeping the previous sample.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            lr_s_r   <= 1'b0;
            lr_p_r   <= 1'b0;
            lr_upd_r <= 1'b0;
        end else begin
            lr_upd_r <= sclk_rise_s;
            if (sclk_rise_s) begin
                lr_p_r <= lr_s_r;
                lr_s_r <= lrclk_sync_r[1];
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and load decode; a 1-to-0 LRCLK change always starts a new frame.
    always_comb begin
        state_nxt_s  = state_r;
        load_left_s  = 1'b0;
        load_right_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (lr_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LEFT: begin
                if (lr_rise_s) begin
                    state_nxt_s  = RIGHT;
                    load_right_s = 1'b1;
                end else if (lr_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            RIGHT: begin
                if (lr_fall_s) begin
                    state_nxt_s = LEFT;
                    load_left_s = 1'b1;
                end else if (lr_rise_s) begin
                    state_nxt_s  = RIGHT;
                    load_right_s = 1'b1;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Holding register; a load that finds it empty is an underrun even if a pair is accepted that clk.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            hold_full_r <= 1'b0;
            hold_l_r    <= {SAMPLE_W{1'b0}};
            hold_r_r    <= {SAMPLE_W{1'b0}};
        end else if (accept_s) begin
            hold_full_r <= 1'b1;
            hold_l_r    <= sample_l;
            hold_r_r    <= sample_r;
        end else if (load_left_s && hold_full_r) begin
            hold_full_r <= 1'b0;
        end
    end

    // Frame load, underrun accounting and strobe.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            frame_r_r      <= {SAMPLE_W{1'b0}};
            underrun_cnt_r <= 16'h0000;
            frame_strobe_r <= 1'b0;
        end else begin
            frame_strobe_r <= load_left_s;
            if (load_left_s) begin
                if (hold_full_r) begin
                    frame_r_r <= hold_r_r;
                end else begin
                    frame_r_r      <= {SAMPLE_W{1'b0}};
                    underrun_cnt_r <= sat_inc16(underrun_cnt_r);
                end
            end
        end
    end

    // Shifter: loads on channel changes, shifts on SCLK falls; an early change simply truncates.
    always_ff @(posedge clk) begin
        if (Reset_h) begin
            shift_r   <= {SAMPLE_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            dout_r    <= 1'b0;
        end else if (load_left_s) begin
            shift_r   <= hold_full_r ? hold_l_r : {SAMPLE_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (load_right_s) begin
            shift_r   <= frame_r_r;
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (sclk_fall_s && (state_r != IDLE)) begin
            if (bit_cnt_r < SAMPLE_LIM) begin
                dout_r  <= shift_r[SAMPLE_W-1];
                shift_r <= {shift_r[SAMPLE_W-2:0], 1'b0};
            end else begin
                dout_r <= 1'b0;
            end
            if (bit_cnt_r < SLOT_LIM) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: the bench plays the codec (SCLK = 16 clk) and
// records dout at the end of every SCLK low phase.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        Reset_h;
    logic        sclk_in;
    logic        lrclk_in;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        dout;
    logic        frame_strobe;
    logic [15:0] underrun_cnt;

    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   ready_hi_cnt = 0;
    logic acc_flag = 1'b0;
    logic cap [0:127];

    always #10 clk = ~clk;

    i2s_tx #(.SAMPLE_W(16), .SLOT_W(32)) dut (
        .clk          (clk),
        .Reset_h      (Reset_h),
        .sclk_in      (sclk_in),
        .lrclk_in     (lrclk_in),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dout         (dout),
        .frame_strobe (frame_strobe),
        .underrun_cnt (underrun_cnt)
    );

    // Handshake and strobe bookkeeping at the active edge.
    always @(posedge clk) begin
        acc_flag <= sample_valid & sample_ready;
        if (frame_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        if (acc_flag) sample_valid = 1'b0;
        if (sample_ready) ready_hi_cnt++;
    endtask

    // One SCLK period; LRCLK changes with the falling edge, as a codec drives it.
    task automatic sclk_period(input logic lr, output logic b);
        sclk_in  = 1'b0;
        lrclk_in = lr;
        repeat (8) tick();
        b = dout;
        sclk_in = 1'b1;
        repeat (8) tick();
    endtask

    task automatic run_frame(input int nl, input int nr);
        logic b;
        for (int i = 0; i < nl + nr; i++) begin
            sclk_period((i < nl) ? 1'b0 : 1'b1, b);
            cap[i] = b;
        end
    endtask

    function automatic logic [15:0] pack16(input int s);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[15-i] = cap[s+i];
        return v;
    endfunction

    function automatic int ones(input int s, input int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (cap[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic do_reset();
        Reset_h      = 1'b1;
        sample_valid = 1'b0;
        repeat (3) tick();
        Reset_h = 1'b0;
        tick();
    endtask

    task automatic preamble();
        logic b;
        repeat (3) sclk_period(1'b1, b);
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 2000 && sample_valid; i++) tick();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL offer_accept: pair %h/%h still pending, required accepted", l, r);
            sample_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset_h = 1'b1; sclk_in = 1'b1; lrclk_in = 1'b1;
        sample_l = 16'h1111; sample_r = 16'h2222; sample_valid = 1'b1;
        repeat (4) tick();
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b, expected 0", dout); end
        checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b, expected 0", frame_strobe); end
        checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL rst_underrun: got %h, expected 0000", underrun_cnt); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, expected 0", sample_ready); end
        Reset_h = 1'b0; sample_valid = 1'b0;
        tick();
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", sample_ready); end
    endtask

    task automatic test_common();
        int s0;
        do_reset(); preamble();
        offer(16'hA5C3, 16'h0F01);
        s0 = strobe_cnt;
        run_frame(32, 32);
        checks++; if (pack16(1) !== 16'hA5C3) begin errors++; $display("FAIL common_left: got %h, expected a5c3", pack16(1)); end
        checks++; if (pack16(17) !== 16'h0000) begin errors++; $display("FAIL common_left_pad: got %h, expected 0000", pack16(17)); end
        checks++; if (pack16(33) !== 16'h0F01) begin errors++; $display("FAIL common_right: got %h, expected 0f01", pack16(33)); end
        checks++; if (ones(49, 15) !== 0) begin errors++; $display("FAIL common_right_pad: got %0d ones, expected 0", ones(49, 15)); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL common_strobe: got %0d pulses, expected 1", strobe_cnt - s0); end
        checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL common_underrun: got %h, expected 0000", underrun_cnt); end
    endtask

    task automatic test_underrun();
        int s0, tot;
        do_reset(); preamble();
        s0 = strobe_cnt; ready_hi_cnt = 0; tot = 0;
        for (int f = 0; f < 3; f++) begin
            run_frame(4, 4);
            tot += ones(0, 8);
        end
        checks++; if (tot !== 0) begin errors++; $display("FAIL underrun_dout: got %0d ones, expected 0", tot); end
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL underrun_cnt: got %0d, expected 3", underrun_cnt); end
        checks++; if (ready_hi_cnt !== 3 * 8 * 16) begin errors++; $display("FAIL underrun_ready: got %0d ready clks, expected 384", ready_hi_cnt); end
        checks++; if (strobe_cnt - s0 !== 3) begin errors++; $display("FAIL underrun_strobe: got %0d, expected 3", strobe_cnt - s0); end
    endtask

    task automatic test_saturate();
        do_reset(); preamble();
        dut.underrun_cnt_r = 16'hFFFE;
        tick();
        checks++; if (underrun_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preset: got %h, expected fffe", underrun_cnt); end
        for (int k = 0; k < 3; k++) begin
            run_frame(4, 4);
            checks++;
            if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_%0d: got %h, expected ffff", k, underrun_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        do_reset(); preamble();
        offer(16'h1357, 16'h2468);
        sample_l = 16'hFEDC; sample_r = 16'h0BA9; sample_valid = 1'b1;
        ready_hi_cnt = 0;
        preamble();
        checks++; if (ready_hi_cnt !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d ready clks, expected 0", ready_hi_cnt); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_pending: got taken, expected pending"); end
        s0 = strobe_cnt;
        run_frame(32, 32);
        checks++; if (pack16(1) !== 16'h1357) begin errors++; $display("FAIL b2b_first_left: got %h, expected 1357", pack16(1)); end
        checks++; if (pack16(33) !== 16'h2468) begin errors++; $display("FAIL b2b_first_right: got %h, expected 2468", pack16(33)); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_taken: got pending, expected taken"); end
        run_frame(32, 32);
        checks++; if (pack16(1) !== 16'hFEDC) begin errors++; $display("FAIL b2b_second_left: got %h, expected fedc", pack16(1)); end
        checks++; if (pack16(33) !== 16'h0BA9) begin errors++; $display("FAIL b2b_second_right: got %h, expected 0ba9", pack16(33)); end
        checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL b2b_underrun: got %h, expected 0000", underrun_cnt); end
        checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_strobe: got %0d, expected 2", strobe_cnt - s0); end
    endtask

    // LRCLK high again on the 8th SCLK period: only 7 left bits (c35a -> 1100001) go out.
    task automatic test_early_lr();
        logic [6:0] l7;
        do_reset(); preamble();
        offer(16'hC35A, 16'h9E27);
        run_frame(7, 32);
        for (int i = 0; i < 7; i++) l7[6-i] = cap[1+i];
        checks++; if (l7 !== 7'h61) begin errors++; $display("FAIL early_left_trunc: got %h, expected 61", l7); end
        checks++; if (pack16(8) !== 16'h9E27) begin errors++; $display("FAIL early_right: got %h, expected 9e27", pack16(8)); end
        checks++; if (ones(24, 15) !== 0) begin errors++; $display("FAIL early_right_pad: got %0d ones, expected 0", ones(24, 15)); end
    endtask

    task automatic test_reset_mid();
        logic b;
        int s0;
        do_reset(); preamble();
        offer(16'hA5C3, 16'h0F01);
        for (int i = 0; i < 4; i++) begin
            sclk_period(1'b0, b);
            cap[i] = b;
        end
        offer(16'hFFFF, 16'hFFFF);
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL mid_pre_dout: got %b, expected 1", dout); end
        Reset_h = 1'b1;
        #1;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, expected 0", sample_ready); end
        tick();
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL mid_rst_dout: got %b, expected 0", dout); end
        checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL mid_rst_underrun: got %h, expected 0000", underrun_cnt); end
        Reset_h = 1'b0;
        tick();
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL mid_hold_discard: got ready %b, expected 1", sample_ready); end
        offer(16'h6C81, 16'h4002);
        s0 = strobe_cnt;
        run_frame(28, 32);
        checks++; if (ones(0, 60) !== 0) begin errors++; $display("FAIL mid_idle_dout: got %0d ones, expected 0", ones(0, 60)); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL mid_idle_strobe: got %0d, expected 0", strobe_cnt - s0); end
        run_frame(32, 32);
        checks++; if (pack16(1) !== 16'h6C81) begin errors++; $display("FAIL mid_next_left: got %h, expected 6c81", pack16(1)); end
        checks++; if (pack16(33) !== 16'h4002) begin errors++; $display("FAIL mid_next_right: got %h, expected 4002", pack16(33)); end
        checks++; if (underrun_cnt !== 16'h0000) begin errors++; $display("FAIL mid_underrun: got %h, expected 0000", underrun_cnt); end
    endtask

    initial begin
        test_reset();
        test_common();
        test_underrun();
        test_saturate();
        test_back_to_back();
        test_early_lr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
